// File: rtl/wv_fetch_ctrl.sv
// Wv weight-memory read sequencer.
// Walks a contiguous row range, absorbs the 1-cycle registered read latency through a
// 2-entry output buffer and streams words over valid/ready. Host weight-load writes
// share the single memory port and are only accepted while idle.
module wv_fetch_ctrl #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned ROWS          = 128,
  parameter int unsigned WORDS_PER_ROW = 16,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        row_start,
  input  logic [8:0]        row_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [WIDTH-1:0]  host_wr_data,
  output logic              host_wr_ready,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [7:0]        out_row,
  output logic              out_last
);

  localparam int unsigned WordW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [WordW-1:0] LastWord = WordW'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        last_row_q, last_row_d;
  logic [WordW-1:0]  word_q, word_d;
  logic              err_q, err_d;

  // Tag of the read issued last cycle; its data is on mem_rdata this cycle.
  logic              infl_q;
  logic [7:0]        infl_row_q;
  logic              infl_last_q;

  // 2-entry output buffer.
  logic [1:0][WIDTH-1:0] fifo_data_q;
  logic [1:0][7:0]       fifo_row_q;
  logic [1:0]            fifo_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;

  logic              push, pop, issue, issue_last, can_issue, cmd_bad;
  logic [1:0]        occ;
  logic [9:0]        range_end;
  logic [ADDR_W-1:0] start_addr;

  assign range_end  = {2'b00, row_start} + {1'b0, row_count};
  assign cmd_bad    = (row_count == 9'd0) || (range_end > 10'(ROWS));
  assign start_addr = base_addr + ADDR_W'(row_start) * ADDR_W'(WORDS_PER_ROW);
  assign issue_last = (row_q == last_row_q) && (word_q == LastWord);

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_row   = fifo_row_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];

  assign push = infl_q;
  assign pop  = out_valid && out_ready;

  // Buffered plus in-flight words; a same-cycle pop frees a slot for the next read.
  assign occ       = cnt_q + {1'b0, infl_q};
  assign can_issue = pop ? (occ <= 2'd2) : (occ < 2'd2);

  // Next-state, read sequencing and memory-port arbitration.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    row_d         = row_q;
    last_row_d    = last_row_q;
    word_d        = word_q;
    err_d         = err_q;
    issue         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    host_wr_ready = 1'b0;
    mem_write_en  = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          // Start wins over a same-cycle host write.
          err_d      = cmd_bad;
          addr_d     = start_addr;
          row_d      = row_start;
          last_row_d = 8'(range_end - 10'd1);
          word_d     = '0;
          state_d    = cmd_bad ? StFin : StFetch;
        end else if (host_wr_valid) begin
          host_wr_ready = 1'b1;
          mem_write_en  = 1'b1;
          mem_addr      = host_wr_addr;
          mem_wdata     = host_wr_data;
        end
      end
      StFetch: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (can_issue) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (word_q == LastWord) begin
            word_d = '0;
            row_d  = row_q + 8'd1;
          end else begin
            word_d = word_q + WordW'(1);
          end
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        // Leave once the buffer empties, counting a pop of the final entry this cycle.
        if (!infl_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) state_d = StFin;
      end
      StFin: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      row_q       <= '0;
      last_row_q  <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_row_q  <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      last_row_q  <= last_row_d;
      word_q      <= word_d;
      err_q       <= err_d;
      infl_q      <= issue;
      infl_row_q  <= row_q;
      infl_last_q <= issue_last;
    end
  end

  // Output buffer: capture read data the cycle after issue, pop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q <= '0;
      fifo_row_q  <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_rdata;
        fifo_row_q[wr_ptr_q]  <= infl_row_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wv_fetch_ctrl.sv
// Randomized self-checking bench for wv_fetch_ctrl with a registered-read memory model.
module tb_wv_fetch_ctrl;

  localparam int unsigned Width = 64;
  localparam int unsigned Rows  = 128;
  localparam int unsigned Wpr   = 16;
  localparam int unsigned AddrW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [AddrW-1:0] base_addr;
  logic [7:0]       row_start;
  logic [8:0]       row_count;
  logic             busy, done, err;
  logic             host_wr_valid;
  logic [AddrW-1:0] host_wr_addr;
  logic [Width-1:0] host_wr_data;
  logic             host_wr_ready;
  logic             mem_write_en;
  logic [AddrW-1:0] mem_addr;
  logic [Width-1:0] mem_wdata;
  logic [Width-1:0] mem_rdata = '0;
  logic             out_valid, out_ready, out_last;
  logic [Width-1:0] out_data;
  logic [7:0]       out_row;

  always #5 clk = ~clk;

  wv_fetch_ctrl #(
    .WIDTH        (Width),
    .ROWS         (Rows),
    .WORDS_PER_ROW(Wpr),
    .ADDR_W       (AddrW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .row_start    (row_start),
    .row_count    (row_count),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .host_wr_valid(host_wr_valid),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ready(host_wr_ready),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_last     (out_last)
  );

  // Single-port memory with a 1-cycle registered read; 4K words, address wraps.
  logic [63:0] mem [4096];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[11:0]] <= mem_wdata;
    else              mem_rdata <= mem[mem_addr[11:0]];
  end

  // Reference contents, updated only from writes the bench expects to be accepted.
  logic [63:0] ref_mem [4096];
  logic [63:0] exp_data [$];
  logic [7:0]  exp_row  [$];
  logic        exp_last [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      2:       return $urandom_range(0, 3) != 0;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  task automatic check_reset_vals();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_row", out_row, 0);
    check_eq("rst_mem_write_en", mem_write_en, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_host_wr_ready", host_wr_ready, 0);
  endtask

  // Back-to-back host writes while idle; random data unless fixed pattern requested.
  task automatic host_burst(input int a0, input int n, input bit fixed);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      host_wr_valid = 1'b1;
      host_wr_addr  = 32'(a0 + i);
      host_wr_data  = fixed ? (64'h0102030405060708 + 64'(i)) : {$urandom, $urandom};
      @(negedge clk);
      check_eq("host_wr_ready", host_wr_ready, 1);
      ref_mem[host_wr_addr[11:0]] = host_wr_data;
    end
    @(posedge clk); #1;
    host_wr_valid = 1'b0;
  endtask

  // One command: expected stream built from row/word arithmetic over ref_mem.
  task automatic run_cmd(input logic [31:0] b, input int rs, input int rc, input int mode,
                         input bit hw, input logic [31:0] hw_a, input logic [63:0] hw_d);
    bit          legal, got_done, stall;
    int          cyc, last_acc, budget;
    logic [63:0] pd;
    logic [7:0]  pr;
    logic        pl;
    legal = (rc != 0) && ((rs + rc) <= int'(Rows));
    exp_data.delete();
    exp_row.delete();
    exp_last.delete();
    if (legal) begin
      for (int r = rs; r < rs + rc; r++) begin
        for (int w = 0; w < int'(Wpr); w++) begin
          logic [31:0] a;
          a = b + 32'(r * int'(Wpr) + w);
          exp_data.push_back(ref_mem[a[11:0]]);
          exp_row.push_back(8'(r));
          exp_last.push_back((r == rs + rc - 1) && (w == int'(Wpr) - 1));
        end
      end
    end
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    row_start = 8'(rs);
    row_count = 9'(rc);
    out_ready = ready_for(mode, 0);
    if (hw) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = hw_a;
      host_wr_data  = hw_d;
    end
    @(negedge clk);
    if (hw) begin
      check_eq("hw_blocked_at_start", host_wr_ready, 0);
      check_eq("no_write_at_start", mem_write_en, 0);
    end
    check_eq("idle_not_busy", busy, 0);
    cyc = 0; got_done = 0; stall = 0; last_acc = 0;
    pd = '0; pr = '0; pl = 1'b0;
    budget = rc * int'(Wpr) * 8 + 40;
    while (!got_done && cyc < budget) begin
      @(posedge clk); #1;
      // Stray start pulses while busy must be ignored.
      start     = (mode == 3) && ($urandom_range(0, 7) == 0);
      base_addr = $urandom;
      row_start = 8'($urandom);
      row_count = 9'($urandom);
      out_ready = ready_for(mode, cyc + 1);
      @(negedge clk);
      cyc++;
      if (hw) check_eq("hw_blocked", host_wr_ready, 0);
      if (stall) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, pd);
        check_eq("stall_row", out_row, pr);
        check_eq("stall_last", out_last, pl);
      end
      if (exp_data.size() == 0) begin
        check_eq("spurious_valid", out_valid, 0);
      end else if (out_valid && out_ready) begin
        check_eq("beat_data", out_data, exp_data.pop_front());
        check_eq("beat_row", out_row, exp_row.pop_front());
        check_eq("beat_last", out_last, exp_last.pop_front());
        last_acc = cyc;
      end
      stall = out_valid && !out_ready;
      pd = out_data; pr = out_row; pl = out_last;
      if (done) begin
        got_done = 1;
        check_eq("err_at_done", err, !legal);
        check_eq("busy_at_done", busy, 0);
        check_eq("words_left", exp_data.size(), 0);
        if (legal) check_eq("done_after_last", cyc - last_acc, 1);
        else       check_eq("bad_done_quick", cyc <= 2, 1);
      end else begin
        check_eq("busy", busy, legal);
        check_eq("err_quiet", err, 0);
      end
    end
    check_eq("done_seen", got_done, 1);
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("idle_after_fin", busy, 0);
    if (hw) begin
      check_eq("hw_accept_after", host_wr_ready, 1);
      ref_mem[hw_a[11:0]] = hw_d;
      @(posedge clk); #1;
      host_wr_valid = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, c;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; row_start = '0; row_count = '0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0; out_ready = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    host_burst(0, 4096, 1'b0);
    host_burst(0, 16, 1'b1);

    run_cmd(32'd0, 0, 1, 0, 1'b0, 32'd0, 64'd0);
    run_cmd(32'd0, 5, 2, 0, 1'b0, 32'd0, 64'd0);
    run_cmd(32'd0, 5, 2, 1, 1'b0, 32'd0, 64'd0);
    run_cmd(32'd0, 0, 0, 0, 1'b0, 32'd0, 64'd0);
    run_cmd(32'd0, 120, 9, 0, 1'b0, 32'd0, 64'd0);
    run_cmd(32'd0, 5, 2, 0, 1'b1, 32'h35, 64'hDEAD_BEEF_CAFE_F00D);
    run_cmd(32'd0, 3, 1, 0, 1'b0, 32'd0, 64'd0);

    // Reset in the middle of a fetch.
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; row_start = 8'd0; row_count = 9'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0; c = 0;
    while (beats < 7 && c < 200) begin
      @(negedge clk);
      c++;
      if (out_valid && out_ready) beats++;
    end
    check_eq("rst_mid_reached", beats, 7);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    run_cmd(32'd0, 0, 128, 0, 1'b0, 32'd0, 64'd0);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] b;
      int rs, rc;
      b  = 32'($urandom_range(0, 4095));
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 127);
      rc = $urandom_range(0, 12);
      run_cmd(b, rs, rc, $urandom_range(0, 3), 1'b0, 32'd0, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
